// File: rtl/demux_router_4_pkg.sv
// rtl/demux_router_4_pkg.sv - shared constants and types for the 1-to-4 demux router
package demux_router_4_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 2;
    localparam int NUM_CH     = 4;
    localparam int PTR_W      = $clog2(DEPTH_DEF);

    typedef logic [1:0] ch_sel_t;

    function automatic logic [NUM_CH-1:0] sel_onehot(input ch_sel_t sel);
        return NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_router_4_sync_fifo_ch.sv
// rtl/demux_router_4_sync_fifo_ch.sv - single-clock per-channel FIFO with count and sync reset
module sync_fifo_ch
    import demux_router_4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CW-1:0]     count_o
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Gating here keeps the FIFO safe even if a caller misbehaves.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head word reads zero afterwards.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i) !(push_i && full_o));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (reset_i) !(pop_i && empty_o));
    a_count_max:    assert property (@(posedge clk_i) count_q <= FULL_CNT);

endmodule

// File: rtl/demux_router_4.sv
// rtl/demux_router_4.sv - registered 1-to-4 demultiplexer steering words into per-channel FIFOs
module demux_router_4
    import demux_router_4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  ch_sel_t           in_sel,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic              busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [DATA_W-1:0] head  [NUM_CH];
    logic [CW-1:0]     count [NUM_CH];

    // Readiness looks only at the selected channel's registered fullness,
    // so a same-cycle pop never frees space for a push.
    assign in_ready = !full[in_sel];
    assign push     = (in_valid && in_ready) ? sel_onehot(in_sel) : '0;
    assign pop      = out_valid & out_ready;
    assign busy     = |(~empty);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sync_fifo_ch #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk_i   (CLK),
            .reset_i (RESET),
            .push_i  (push[g]),
            .data_i  (in_data),
            .pop_i   (pop[g]),
            .data_o  (head[g]),
            .full_o  (full[g]),
            .empty_o (empty[g]),
            .count_o (count[g])
        );

        assign out_valid[g] = (count[g] != '0);
    end

    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];
    assign out_data3 = head[3];

endmodule

// File: tb/tb_demux_router_4.sv
// tb/tb_demux_router_4.sv - directed and scoreboarded bench for demux_router_4
module tb_demux_router_4;

    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_sel = '0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int accepted;
    logic acc;

    logic [31:0] sb [4][$];

    demux_router_4 #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] head_of(input int k);
        case (k)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    task automatic cycle(input logic v, input logic [31:0] d, input logic [1:0] s,
                         input logic [3:0] r, output logic accepted_o);
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        out_ready = r;
        #1;
        check("cyc_in_ready", 32'(in_ready), 32'(sb[s].size() < DEPTH));
        for (int k = 0; k < 4; k++) begin
            check("cyc_out_valid", 32'(out_valid[k]), 32'(sb[k].size() != 0));
            if (sb[k].size() != 0) begin
                check("cyc_out_data", head_of(k), sb[k][0]);
            end
        end
        accepted_o = v && (sb[s].size() < DEPTH);
        for (int k = 0; k < 4; k++) begin
            if (r[k] && sb[k].size() != 0) begin
                void'(sb[k].pop_front());
            end
        end
        if (accepted_o) begin
            sb[s].push_back(d);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset with random inputs
        RESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'($urandom);
            in_data   = $urandom;
            in_sel    = 2'($urandom);
            out_ready = 4'($urandom);
            tick();
        end
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_data0", out_data0, 32'h0);
        check("rst_data1", out_data1, 32'h0);
        check("rst_data2", out_data2, 32'h0);
        check("rst_data3", out_data3, 32'h0);
        in_valid = 1'b0; out_ready = 4'b0000; in_data = '0; in_sel = '0;
        RESET = 1'b0;
        tick();
        check("idle_out_valid", 32'(out_valid), 32'h0);

        // Single route to channel 2
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_sel = 2'd2;
        tick();
        in_valid = 1'b0;
        check("route_out_valid", 32'(out_valid), 32'h4);
        check("route_data2", out_data2, 32'hDEADBEEF);
        check("route_busy", 32'(busy), 32'h1);
        out_ready = 4'b0100;
        tick();
        out_ready = 4'b0000;
        check("route_drained", 32'(out_valid), 32'h0);
        check("route_idle_busy", 32'(busy), 32'h0);

        // Fill channel 1 and backpressure
        in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h1;
        tick();
        in_data = 32'h2;
        tick();
        in_data = 32'h3;
        #1;
        check("bp_in_ready_full", 32'(in_ready), 32'h0);
        tick();
        check("bp_out_valid", 32'(out_valid), 32'h2);
        check("bp_head_held", out_data1, 32'h1);
        in_sel = 2'd3;
        #1;
        check("bp_other_ch_ready", 32'(in_ready), 32'h1);
        in_sel = 2'd1;
        out_ready = 4'b0010;
        tick();
        check("bp_second_head", out_data1, 32'h2);
        check("bp_ready_after_pop", 32'(in_ready), 32'h1);
        tick();
        check("bp_third_head", out_data1, 32'h3);
        check("bp_valid_third", 32'(out_valid), 32'h2);
        in_valid = 1'b0;
        tick();
        out_ready = 4'b0000;
        check("bp_drained", 32'(out_valid), 32'h0);

        // Full channel popped in the same cycle a push is offered
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hA0;
        tick();
        in_data = 32'hA1;
        tick();
        in_data = 32'hA2; out_ready = 4'b0001;
        #1;
        check("fp_in_ready_full", 32'(in_ready), 32'h0);
        tick();
        check("fp_head_after_pop", out_data0, 32'hA1);
        check("fp_ready_count1", 32'(in_ready), 32'h1);
        out_ready = 4'b0000;
        tick();
        in_valid = 1'b0;
        check("fp_valid", 32'(out_valid), 32'h1);
        check("fp_head_stable", out_data0, 32'hA1);
        out_ready = 4'b0001;
        tick();
        check("fp_late_word", out_data0, 32'hA2);
        tick();
        out_ready = 4'b0000;
        check("fp_drained", 32'(out_valid), 32'h0);

        // Streaming with scoreboard
        accepted = 0;
        for (int c = 0; c < 2000 && accepted < 100; c++) begin
            cycle($urandom_range(0, 9) < 7, $urandom, 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), acc);
            if (acc) accepted++;
        end
        check("stream_words", 32'(accepted), 32'd100);
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, 32'h0, 2'd0, 4'hF, acc);
        end
        check("stream_busy_end", 32'(busy), 32'h0);

        // Reset while every channel holds a word
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 32'hC0DE0000 + 32'(k), 2'(k), 4'h0, acc);
        end
        check("mid_all_valid", 32'(out_valid), 32'hF);
        in_valid = 1'b0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int k = 0; k < 4; k++) sb[k].delete();
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_data0", out_data0, 32'h0);
        check("mid_rst_data3", out_data3, 32'h0);
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 32'h0, 2'd0, 4'hF, acc);
        end
        cycle(1'b1, 32'h00005A5A, 2'd2, 4'h0, acc);
        cycle(1'b0, 32'h0, 2'd0, 4'hF, acc);
        cycle(1'b0, 32'h0, 2'd0, 4'hF, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
